// File: rtl/ysyx_22041412_muldiv_ctrl_pkg.sv
// Shared constants for the iterative RV64M multiply/divide unit: M-extension func3 codes,
// controller state encoding, and the special-case decoder.
package ysyx_22041412_muldiv_ctrl_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // The decoder raises this on funct7 == FUNCT7_MULDIV to steer an op to this unit.
    localparam logic       MUL_EN        = 1'b1;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic        hit;
        logic [63:0] value;
    } special_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Operations whose result is known at accept time and skip the iterative datapath.
    function automatic special_t decode_special(input logic [2:0]  f3,
                                                input logic        word,
                                                input logic [63:0] a,
                                                input logic [63:0] b);
        special_t    s;
        logic        div_zero;
        logic        ovf;
        logic [63:0] dividend;
        s.hit    = 1'b0;
        s.value  = '0;
        dividend = word ? sext32(a[31:0]) : a;
        div_zero = word ? (b[31:0] == 32'h0) : (b == 64'h0);
        ovf      = !f3[0] && (word ? ((a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF))
                                   : ((a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF)));
        if (word && !f3[2] && (f3 != F3_MUL)) begin
            s.hit   = 1'b1;
            s.value = '0;
        end else if (f3[2] && div_zero) begin
            s.hit   = 1'b1;
            s.value = f3[1] ? dividend : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (f3[2] && ovf) begin
            s.hit   = 1'b1;
            s.value = f3[1] ? 64'h0 : dividend;
        end
        return s;
    endfunction

endpackage

// File: rtl/ysyx_22041412_muldiv_core.sv
// Datapath of the multiply/divide unit: magnitude conversion, 128-bit shift-add / restoring
// divide accumulator, sign fix and the result register. Sequenced by start/step/fix strobes.
module ysyx_22041412_muldiv_core
    import ysyx_22041412_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            fix_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    input  logic [2:0]      func3_i,
    input  logic            is_word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic [XLEN-1:0] result_o
);

    localparam int HALF = XLEN / 2;

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        func3_q, func3_d;
    logic              word_q, word_d;
    logic              neg_q, neg_d;
    logic              neg_r_q, neg_r_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs, a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   sub;
    logic              ge;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, quo_f, rem_f, div_sel, mul_val, div_val, fix_val;

    // Signed operands become magnitudes at start; the signs are kept for the final fix.
    always_comb begin
        a_signed = (func3_i == F3_MULH) || (func3_i == F3_MULHSU) ||
                   (func3_i == F3_DIV)  || (func3_i == F3_REM);
        b_signed = (func3_i == F3_MULH) || (func3_i == F3_DIV) || (func3_i == F3_REM);
        a_neg    = a_signed && (is_word_i ? src1_i[HALF-1] : src1_i[XLEN-1]);
        b_neg    = b_signed && (is_word_i ? src2_i[HALF-1] : src2_i[XLEN-1]);
        a_abs    = a_neg ? -src1_i : src1_i;
        b_abs    = b_neg ? -src2_i : src2_i;
        a_mag    = is_word_i ? {{HALF{1'b0}}, a_abs[HALF-1:0]} : a_abs;
        b_mag    = is_word_i ? {{HALF{1'b0}}, b_abs[HALF-1:0]} : b_abs;
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        trial    = acc_q[2*XLEN-1:XLEN-1];
        sub      = trial[XLEN-1:0] - opnd_q;
        ge       = trial[XLEN] || (trial[XLEN-1:0] >= opnd_q);
        div_next = ge ? {sub, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
    end

    // A word multiply ends with its product sitting 32 bits up in the accumulator.
    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        mul_val = (func3_q == F3_MUL) ? (word_q ? sext32(prod[XLEN-1:HALF]) : prod[XLEN-1:0])
                                      : prod[2*XLEN-1:XLEN];
        quo     = word_q ? {{HALF{1'b0}}, acc_q[HALF-1:0]} : acc_q[XLEN-1:0];
        rem     = acc_q[2*XLEN-1:XLEN];
        quo_f   = neg_q ? -quo : quo;
        rem_f   = neg_r_q ? -rem : rem;
        div_sel = func3_q[1] ? rem_f : quo_f;
        div_val = word_q ? sext32(div_sel[HALF-1:0]) : div_sel;
        fix_val = func3_q[2] ? div_val : mul_val;
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        func3_d  = func3_q;
        word_d   = word_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        if (start_i) begin
            func3_d = func3_i;
            word_d  = is_word_i;
            neg_d   = a_neg ^ b_neg;
            neg_r_d = a_neg;
            if (func3_i[2]) begin
                opnd_d = b_mag;
                acc_d  = is_word_i ? {{XLEN{1'b0}}, a_mag[HALF-1:0], {HALF{1'b0}}}
                                   : {{XLEN{1'b0}}, a_mag};
            end else begin
                opnd_d = a_mag;
                acc_d  = {{XLEN{1'b0}}, b_mag};
            end
        end else if (step_i) begin
            acc_d = func3_q[2] ? div_next : mul_next;
        end
        if (fix_i) begin
            result_d = fix_val;
        end else if (load_i) begin
            result_d = load_val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            func3_q  <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            func3_q  <= func3_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/ysyx_22041412_muldiv_ctrl.sv
// Iterative RV64M multiply/divide unit: valid/ready handshake, IDLE/CALC/FIX/DONE sequencer
// and early completion of the special cases. Stalls the pipeline through busy.
module ysyx_22041412_muldiv_ctrl
    import ysyx_22041412_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    input  logic            flush
);

    logic [1:0] state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       word_q, word_d;
    logic       accept, last;
    logic       start, step, fix, load;
    special_t   special;

    assign special = decode_special(func3, is_word, src1, src2);
    assign accept  = in_valid && in_ready && !flush;
    assign last    = (cnt_q == (word_q ? 7'd31 : 7'd63));

    // Flush overrides every transition and suppresses any strobe that would update the result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        start   = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d = is_word;
                    cnt_d  = 7'd0;
                    if (special.hit) begin
                        load    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        start   = 1'b1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 7'd1;
                if (last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix     = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            step    = 1'b0;
            fix     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state_q == ST_DONE);

    ysyx_22041412_muldiv_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .step_i    (step),
        .fix_i     (fix),
        .load_i    (load),
        .load_val_i(special.value),
        .func3_i   (func3),
        .is_word_i (is_word),
        .src1_i    (src1),
        .src2_i    (src2),
        .result_o  (result)
    );

endmodule
